// File: rtl/qed_dup_issue_pkg.sv
// Shared definitions for the symbolic-QED duplicate-issue source:
// RV32 opcodes, the filler instruction, register-field positions and the
// per-cycle issue decision.
package qed_dup_issue_pkg;

   localparam int unsigned INSN_LEN = 32;

   localparam logic [INSN_LEN-1:0] NOP_INSN = 32'h0000_0013;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;

   localparam int unsigned RD_LSB  = 7;
   localparam int unsigned RD_MSB  = 11;
   localparam int unsigned RS1_LSB = 15;
   localparam int unsigned RS1_MSB = 19;
   localparam int unsigned RS2_LSB = 20;
   localparam int unsigned RS2_MSB = 24;

   typedef enum logic [1:0] {
      ACT_IDLE,
      ACT_ORIG,
      ACT_DUP
   } qed_action_e;

endpackage

// File: rtl/qed_dup_issue_reg_remap.sv
// Combinational register-field decode: moves every present nonzero register
// field into the upper half of the register file and flags any present field
// that already lies in the upper half.
module qed_reg_remap
   import qed_dup_issue_pkg::*;
(
   input  logic [31:0] i_insn,
   output logic [31:0] o_insn,
   output logic        o_high_reg
);

   logic       w_has_rd;
   logic       w_has_rs1;
   logic       w_has_rs2;
   logic [4:0] w_rd;
   logic [4:0] w_rs1;
   logic [4:0] w_rs2;

   assign w_rd  = i_insn[RD_MSB:RD_LSB];
   assign w_rs1 = i_insn[RS1_MSB:RS1_LSB];
   assign w_rs2 = i_insn[RS2_MSB:RS2_LSB];

   // Which register fields the opcode actually carries
   always_comb begin
      w_has_rd  = 1'b0;
      w_has_rs1 = 1'b0;
      w_has_rs2 = 1'b0;
      case (i_insn[6:0])
         OP: begin
            w_has_rd  = 1'b1;
            w_has_rs1 = 1'b1;
            w_has_rs2 = 1'b1;
         end
         OP_IMM, LOAD, JALR: begin
            w_has_rd  = 1'b1;
            w_has_rs1 = 1'b1;
         end
         STORE, BRANCH: begin
            w_has_rs1 = 1'b1;
            w_has_rs2 = 1'b1;
         end
         LUI, AUIPC, JAL: begin
            w_has_rd  = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Setting bit 4 of a nonzero field maps xN to x(N+16); x0 is left alone
   always_comb begin
      o_insn = i_insn;
      if (w_has_rd  && (w_rd  != '0)) o_insn[RD_MSB]  = 1'b1;
      if (w_has_rs1 && (w_rs1 != '0)) o_insn[RS1_MSB] = 1'b1;
      if (w_has_rs2 && (w_rs2 != '0)) o_insn[RS2_MSB] = 1'b1;
      o_high_reg = (w_has_rd  && w_rd[4])  ||
                   (w_has_rs1 && w_rs1[4]) ||
                   (w_has_rs2 && w_rs2[4]);
   end

endmodule

// File: rtl/qed_dup_issue.sv
// Symbolic-QED instruction source: buffers original instructions in a FIFO,
// replays them as register-remapped duplicates on command, and tracks the
// counts needed for the QED consistency check.
module qed_dup_issue #(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned CNT_W    = 16,
   parameter logic [31:0] NOP_INSN = qed_dup_issue_pkg::NOP_INSN
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             exec_dup,
   input  logic [31:0]      inst_in,
   input  logic             inst_in_valid,
   output logic [31:0]      inst_out,
   output logic             inst_out_valid,
   output logic             inst_out_is_dup,
   output logic [CNT_W-1:0] orig_cnt,
   output logic [CNT_W-1:0] dup_cnt,
   output logic             fifo_full,
   output logic             fifo_empty,
   output logic             qed_ready,
   output logic             orig_violation
);

   import qed_dup_issue_pkg::*;

   localparam int unsigned AW = $clog2(DEPTH);

   logic [31:0]      r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [CNT_W-1:0] r_orig_cnt;
   logic [CNT_W-1:0] r_dup_cnt;
   logic [31:0]      r_inst_out;
   logic             r_valid;
   logic             r_is_dup;
   logic             r_qed_ready;
   logic             r_violation;

   logic             w_full;
   logic             w_empty;
   logic [31:0]      w_head;
   logic [31:0]      w_remap_in;
   logic [31:0]      w_remap_out;
   logic             w_remap_high;
   qed_action_e      w_act;
   logic [AW:0]      w_wr_nxt;
   logic [AW:0]      w_rd_nxt;
   logic [CNT_W-1:0] w_orig_nxt;
   logic [CNT_W-1:0] w_dup_nxt;
   logic             w_qed_nxt;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

   // Issue decision: duplicate beats original, otherwise filler
   always_comb begin
      w_act = ACT_IDLE;
      if (exec_dup && !w_empty)
         w_act = ACT_DUP;
      else if (inst_in_valid && !w_full)
         w_act = ACT_ORIG;
   end

   // One remapper serves both paths: remapped word for DUP, high-register flag for ORIG
   assign w_remap_in = (w_act == ACT_DUP) ? w_head : inst_in;

   qed_reg_remap u_remap (
      .i_insn     (w_remap_in),
      .o_insn     (w_remap_out),
      .o_high_reg (w_remap_high)
   );

   // Post-update pointer/count values, so qed_ready reflects this cycle's action
   always_comb begin
      w_wr_nxt   = r_wr_ptr;
      w_rd_nxt   = r_rd_ptr;
      w_orig_nxt = r_orig_cnt;
      w_dup_nxt  = r_dup_cnt;
      case (w_act)
         ACT_ORIG: begin
            w_wr_nxt = r_wr_ptr + 1'b1;
            if (r_orig_cnt != '1) w_orig_nxt = r_orig_cnt + 1'b1;
         end
         ACT_DUP: begin
            w_rd_nxt = r_rd_ptr + 1'b1;
            if (r_dup_cnt != '1) w_dup_nxt = r_dup_cnt + 1'b1;
         end
         default: begin
         end
      endcase
      w_qed_nxt = (w_orig_nxt == w_dup_nxt) && (w_orig_nxt != '0) &&
                  (w_wr_nxt == w_rd_nxt);
   end

   // FIFO storage write on an accepted original
   always_ff @(posedge clk) begin
      if (!stall && (w_act == ACT_ORIG))
         r_mem[r_wr_ptr[AW-1:0]] <= inst_in;
   end

   // Registered issue state; everything holds while the pipeline stalls
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_orig_cnt  <= '0;
         r_dup_cnt   <= '0;
         r_inst_out  <= NOP_INSN;
         r_valid     <= 1'b0;
         r_is_dup    <= 1'b0;
         r_qed_ready <= 1'b0;
         r_violation <= 1'b0;
      end else if (!stall) begin
         r_wr_ptr    <= w_wr_nxt;
         r_rd_ptr    <= w_rd_nxt;
         r_orig_cnt  <= w_orig_nxt;
         r_dup_cnt   <= w_dup_nxt;
         r_qed_ready <= w_qed_nxt;
         case (w_act)
            ACT_DUP: begin
               r_inst_out <= w_remap_out;
               r_valid    <= 1'b1;
               r_is_dup   <= 1'b1;
            end
            ACT_ORIG: begin
               r_inst_out <= inst_in;
               r_valid    <= 1'b1;
               r_is_dup   <= 1'b0;
               if (w_remap_high) r_violation <= 1'b1;
            end
            default: begin
               r_inst_out <= NOP_INSN;
               r_valid    <= 1'b0;
               r_is_dup   <= 1'b0;
            end
         endcase
      end
   end

   assign inst_out        = r_inst_out;
   assign inst_out_valid  = r_valid;
   assign inst_out_is_dup = r_is_dup;
   assign orig_cnt        = r_orig_cnt;
   assign dup_cnt         = r_dup_cnt;
   assign fifo_full       = w_full;
   assign fifo_empty      = w_empty;
   assign qed_ready       = r_qed_ready;
   assign orig_violation  = r_violation;

endmodule

// File: doc/qed_dup_issue.md
Name: qed_dup_issue

Overview:
- Symbolic-QED instruction source sitting directly upstream of the pipeline's `inst1` input in the formal top.
- Accepts constrained original instructions, which use architectural registers x0–x15, and buffers them in a FIFO.
- When commanded, replays each buffered instruction as a duplicate with its registers remapped into x16–x31.
- Tracks original and duplicate counts and raises a consistency-check-ready flag for the property checker.

Parameters:
- DEPTH, 16, FIFO entries (power of two, ≥2).
- CNT_W, 16, width of the issued-instruction counters.
- NOP_INSN, 32'h00000013, filler instruction (`addi x0,x0,0`).

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  pipeline cannot accept an instruction this cycle.
- exec_dup  in  1  symbolic choice: issue a duplicate instead of an original.
- inst_in  in  32  candidate original instruction (INSN_LEN).
- inst_in_valid  in  1  inst_in is offered this cycle.
- inst_out  out  32  instruction presented to the pipeline.
- inst_out_valid  out  1  inst_out is a real original or duplicate, not filler.
- inst_out_is_dup  out  1  inst_out is a duplicate.
- orig_cnt  out  CNT_W  originals issued.
- dup_cnt  out  CNT_W  duplicates issued.
- fifo_full  out  1  FIFO holds DEPTH entries.
- fifo_empty  out  1  FIFO holds 0 entries.
- qed_ready  out  1  orig_cnt==dup_cnt, orig_cnt!=0, FIFO empty.
- orig_violation  out  1  sticky: an accepted original referenced a register ≥16.

Behaviour:
- Reset (async assert, sync deassert):
  - inst_out=NOP_INSN; inst_out_valid=0; inst_out_is_dup=0.
  - Counters=0; FIFO pointers=0, so fifo_empty=1 and fifo_full=0.
  - orig_violation=0; qed_ready=0.
  - A reset mid-sequence discards all buffered entries.
- Outputs are registered, giving one-cycle latency from the decision to inst_out.
- Each cycle when stall=1:
  - All registers hold, including inst_out, inst_out_valid and inst_out_is_dup.
  - No push, no pop, no count change; inst_in is dropped.
- Each cycle when stall=0, exactly one of the following, in priority order:
  - DUP: exec_dup=1 and FIFO not empty.
    - Pop the head entry; inst_out=remap(head); valid=1; is_dup=1; dup_cnt++.
  - ORIG: not DUP, inst_in_valid=1 and FIFO not full.
    - Push inst_in; inst_out=inst_in; valid=1; is_dup=0; orig_cnt++.
  - IDLE: otherwise.
    - inst_out=NOP_INSN; valid=0; is_dup=0.
    - Covers exec_dup=1 with an empty FIFO, and inst_in_valid=1 with a full FIFO (inst_in dropped).
- A push and a pop never occur in the same cycle.
- FIFO pointers have log2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
  - full: the MSBs differ and the low bits are equal.
  - empty: the pointers are equal.
- remap(): for each register field present in the opcode, a nonzero value v becomes v|5'b10000; x0 stays 0.
  - R 0110011: rd, rs1, rs2.
  - I 0010011 / 0000011 / 1100111: rd, rs1.
  - S 0100011, B 1100011: rs1, rs2.
  - U/J 0110111 / 0010111 / 1101111: rd.
  - Any other opcode: passed through unchanged.
  - Immediate, funct and opcode bits are never altered.
- orig_violation sets on an ORIG push when any present field has bit 4 set. It clears only on reset.
- Counters saturate at all-ones and do not wrap.
- qed_ready is registered and computed from the post-update counts and FIFO state.

Decomposition:
- Shared qed package holds:
  - opcode constants (OP, OP_IMM, LOAD, JALR, STORE, BRANCH, LUI, AUIPC, JAL);
  - NOP_INSN;
  - the register-field bit positions (rd[11:7], rs1[19:15], rs2[24:20]).
- One natural sub-module, `qed_reg_remap`: a purely combinational field-presence decode plus remap.
  - It also outputs the high-register flag used for orig_violation.
- The FIFO stays inline.

Test Plan:
- Reset then idle: inst_in_valid=0, exec_dup=0 for 3 cycles → inst_out=0x00000013, valid=0, fifo_empty=1, qed_ready=0.
- Push `add x3,x1,x2` (0x002081B3), then exec_dup=1 with stall=0.
  - Push cycle → inst_out=0x002081B3, is_dup=0.
  - Next cycle → inst_out=0x012889B3, is_dup=1, orig_cnt=dup_cnt=1, qed_ready=1.
- `addi x5,x0,7` (0x00700293) then duplicate → dup inst_out=0x00700A93; the rs1=x0 field is unchanged.
- Fill FIFO: push 16 originals → fifo_full=1; a 17th inst_in_valid → NOP, valid=0, orig_cnt stays 16.
  - Then 16 exec_dup cycles → FIFO drains in order, qed_ready=1.
- Stall=1 asserted with exec_dup=1 and FIFO non-empty → inst_out, counts and FIFO unchanged until stall drops.
- Push `addi x16,x0,0` (0x00000813) → orig_violation=1 next cycle; stays 1 until reset asserted mid-run, then all state returns to reset values.
